hazard_ctrl: RTL and testbench

- Pipeline control unit for the 5-stage MIPS CPU.
- Sits beside the decode stage and produces the per-cycle steering and sequencing signals:
  - operand forwarding selects for the decode-stage A/B muxes;
  - load-use interlock;
  - branch/jump redirect flush;
  - a sequencer for a multi-cycle MUL/DIV unit.
- Owns the only stateful pipeline-control logic: the MUL/DIV occupancy FSM and countdown.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/fwd_sel.sv | 37 +++
 rtl/hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: MUL/DIV sequencer states,
// forwarding-select codes and decoder redirect codes.
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2
    } md_state_e;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_EX = 2'd1;
    localparam logic [1:0] FWD_ME = 2'd2;
    localparam logic [1:0] FWD_MO = 2'd3;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JR     = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding select with EX-over-ME priority; also flags a
// load in EX that this operand depends on.
module fwd_sel
    import pipe_pkg::*;
(
    input  logic [4:0] src,
    input  logic       use_src,
    input  logic [4:0] rw_ex,
    input  logic [4:0] rw_me,
    input  logic       wreg_ex,
    input  logic       wreg_me,
    input  logic       m2reg_ex,
    input  logic       m2reg_me,
    output logic [1:0] sel,
    output logic       load_hit
);

    // r0 is hardwired zero, so it never forwards or interlocks
    always_comb begin
        sel      = FWD_RF;
        load_hit = 1'b0;
        if (use_src && (src != 5'd0)) begin
            if (wreg_ex && !m2reg_ex && (rw_ex == src)) begin
                sel = FWD_EX;
            end else if (wreg_me && (rw_me == src)) begin
                sel = m2reg_me ? FWD_MO : FWD_ME;
            end else begin
                sel = FWD_RF;
            end
            load_hit = wreg_ex && m2reg_ex && (rw_ex == src);
        end else begin
            sel      = FWD_RF;
            load_hit = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: forwarding, load-use interlock, redirect flush and
// MUL/DIV occupancy sequencer. Optional counters under HAZARD_PERF_CNT_EN.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic        clock,
    input  logic        reset_0,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic        use_rs_id,
    input  logic        use_rt_id,
    input  logic [4:0]  rw_ex,
    input  logic [4:0]  rw_me,
    input  logic        wreg_ex,
    input  logic        wreg_me,
    input  logic        m2reg_ex,
    input  logic        m2reg_me,
    input  logic [1:0]  pc_select,
    input  logic        md_start_id,
    input  logic        md_div,
    input  logic        md_use_id,
    input  logic        ext_hold,
    output logic [1:0]  a_select,
    output logic [1:0]  b_select,
    output logic        stall,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        md_issue,
    output logic        md_busy,
    output logic        md_done
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush,
    output logic [31:0] perf_md
`endif
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    md_state_e        state_r;
    md_state_e        state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             load_hit_a_s;
    logic             load_hit_b_s;
    logic             load_stall_s;
    logic             md_stall_s;

    fwd_sel u_fwd_a (
        .src      (rs_id),
        .use_src  (use_rs_id),
        .rw_ex    (rw_ex),
        .rw_me    (rw_me),
        .wreg_ex  (wreg_ex),
        .wreg_me  (wreg_me),
        .m2reg_ex (m2reg_ex),
        .m2reg_me (m2reg_me),
        .sel      (a_select),
        .load_hit (load_hit_a_s)
    );

    fwd_sel u_fwd_b (
        .src      (rt_id),
        .use_src  (use_rt_id),
        .rw_ex    (rw_ex),
        .rw_me    (rw_me),
        .wreg_ex  (wreg_ex),
        .wreg_me  (wreg_me),
        .m2reg_ex (m2reg_ex),
        .m2reg_me (m2reg_me),
        .sel      (b_select),
        .load_hit (load_hit_b_s)
    );

    // Only the two legal busy encodings count as busy, so a corrupted state
    // reads as idle and the next-state default returns it to IDLE.
    assign md_busy      = (state_r == MUL_BUSY) || (state_r == DIV_BUSY);
    assign md_done      = md_busy && (cnt_r == {CNT_W{1'b0}});
    assign load_stall_s = load_hit_a_s || load_hit_b_s;
    // HI/LO readers wait through the done cycle; a new start may overlap it.
    assign md_stall_s   = (md_use_id && md_busy) ||
                          (md_start_id && md_busy && !md_done);
    assign stall        = load_stall_s || md_stall_s;
    assign pc_we        = !stall && !ext_hold;
    assign ifid_we      = !stall && !ext_hold;
    assign idex_bubble  = stall && !ext_hold;
    assign ifid_flush   = (pc_select != PC_SEQ) && !stall && !ext_hold;
    assign md_issue     = md_start_id && !load_stall_s && !ext_hold &&
                          ((state_r == IDLE) || md_done);

    // Sequencer next state; the countdown ignores ext_hold
    always_comb begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
        if (md_issue) begin
            state_nxt_s = md_div ? DIV_BUSY : MUL_BUSY;
            cnt_nxt_s   = md_div ? DIV_LOAD : MUL_LOAD;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
                MUL_BUSY, DIV_BUSY: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_nxt_s = IDLE;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end else begin
                        state_nxt_s = state_r;
                        cnt_nxt_s   = cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Sequencer state and countdown registers
    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Event counters, free-running and wrapping
    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            perf_stall <= 32'd0;
            perf_flush <= 32'd0;
            perf_md    <= 32'd0;
        end else begin
            perf_stall <= perf_stall + {31'd0, (stall && !ext_hold)};
            perf_flush <= perf_flush + {31'd0, ifid_flush};
            perf_md    <= perf_md + {31'd0, md_issue};
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (default MUL_LAT=4, DIV_LAT=32).
module tb_hazard_ctrl;

    logic       clock;
    logic       reset_0;
    logic [4:0] rs_id, rt_id, rw_ex, rw_me;
    logic       use_rs_id, use_rt_id, wreg_ex, wreg_me, m2reg_ex, m2reg_me;
    logic [1:0] pc_select;
    logic       md_start_id, md_div, md_use_id, ext_hold;
    logic [1:0] a_select, b_select;
    logic       stall, pc_we, ifid_we, ifid_flush, idex_bubble;
    logic       md_issue, md_busy, md_done;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall, perf_flush, perf_md;
`endif

    int n_chk;
    int n_fail;

    hazard_ctrl dut (
        .clock(clock), .reset_0(reset_0),
        .rs_id(rs_id), .rt_id(rt_id), .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
        .rw_ex(rw_ex), .rw_me(rw_me), .wreg_ex(wreg_ex), .wreg_me(wreg_me),
        .m2reg_ex(m2reg_ex), .m2reg_me(m2reg_me), .pc_select(pc_select),
        .md_start_id(md_start_id), .md_div(md_div), .md_use_id(md_use_id),
        .ext_hold(ext_hold), .a_select(a_select), .b_select(b_select),
        .stall(stall), .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .md_issue(md_issue), .md_busy(md_busy),
        .md_done(md_done)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_md(perf_md)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to a point 2 time units after the next rising edge
    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_inputs();
        rs_id = 5'd0; rt_id = 5'd0; rw_ex = 5'd0; rw_me = 5'd0;
        use_rs_id = 1'b0; use_rt_id = 1'b0; wreg_ex = 1'b0; wreg_me = 1'b0;
        m2reg_ex = 1'b0; m2reg_me = 1'b0; pc_select = 2'b00;
        md_start_id = 1'b0; md_div = 1'b0; md_use_id = 1'b0; ext_hold = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_0 = 1'b0;
        #12;
        n_chk++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", md_busy); end
        n_chk++; if (pc_we !== 1'b1) begin n_fail++; $display("FAIL rst_pc_we got %b want 1", pc_we); end
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b want 0", stall); end
        n_chk++; if (ifid_flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush got %b want 0", ifid_flush); end
        reset_0 = 1'b1;
        cyc();
        #1;
        n_chk++; if (md_done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", md_done); end
        n_chk++; if (a_select !== 2'd0) begin n_fail++; $display("FAIL rst_asel got %0d want 0", a_select); end
    endtask

    task automatic test_forwarding();
        cyc(); clear_inputs();
        rt_id = 5'd3; use_rt_id = 1'b1; rw_ex = 5'd3; wreg_ex = 1'b1; rw_me = 5'd3; wreg_me = 1'b1;
        #1;
        n_chk++; if (b_select !== 2'd1) begin n_fail++; $display("FAIL fwd_ex_prio got %0d want 1", b_select); end
        rt_id = 5'd0; rw_ex = 5'd0; rw_me = 5'd0;
        #1;
        n_chk++; if (b_select !== 2'd0) begin n_fail++; $display("FAIL fwd_r0 got %0d want 0", b_select); end
        rt_id = 5'd7; rw_ex = 5'd1; rw_me = 5'd7; m2reg_me = 1'b1;
        #1;
        n_chk++; if (b_select !== 2'd3) begin n_fail++; $display("FAIL fwd_me_load got %0d want 3", b_select); end
        m2reg_me = 1'b0;
        #1;
        n_chk++; if (b_select !== 2'd2) begin n_fail++; $display("FAIL fwd_me_alu got %0d want 2", b_select); end
        rw_ex = 5'd7; m2reg_ex = 1'b1;
        #1;
        n_chk++; if (b_select !== 2'd2) begin n_fail++; $display("FAIL fwd_ex_load_skips got %0d want 2", b_select); end
        n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fwd_ex_load_stall got %b want 1", stall); end
        use_rt_id = 1'b0;
        #1;
        n_chk++; if (b_select !== 2'd0 || stall !== 1'b0) begin n_fail++; $display("FAIL fwd_unused got sel %0d stall %b want 0 0", b_select, stall); end
        rs_id = 5'd9; use_rs_id = 1'b1; rw_ex = 5'd9; m2reg_ex = 1'b0;
        #1;
        n_chk++; if (a_select !== 2'd1) begin n_fail++; $display("FAIL fwd_a_ex got %0d want 1", a_select); end
    endtask

    task automatic test_load_use();
        cyc(); clear_inputs();
        rw_ex = 5'd5; wreg_ex = 1'b1; m2reg_ex = 1'b1; rs_id = 5'd5; use_rs_id = 1'b1;
        #1;
        n_chk++; if (stall !== 1'b1 || idex_bubble !== 1'b1) begin n_fail++; $display("FAIL lu_stall got stall %b bubble %b want 1 1", stall, idex_bubble); end
        n_chk++; if (pc_we !== 1'b0 || ifid_we !== 1'b0) begin n_fail++; $display("FAIL lu_we got pc %b ifid %b want 0 0", pc_we, ifid_we); end
        cyc();
        wreg_ex = 1'b0; m2reg_ex = 1'b0; rw_ex = 5'd0;
        rw_me = 5'd5; wreg_me = 1'b1; m2reg_me = 1'b1;
        #1;
        n_chk++; if (stall !== 1'b0 || idex_bubble !== 1'b0) begin n_fail++; $display("FAIL lu_release got stall %b bubble %b want 0 0", stall, idex_bubble); end
        n_chk++; if (a_select !== 2'd3) begin n_fail++; $display("FAIL lu_asel got %0d want 3", a_select); end
    endtask

    task automatic test_redirect();
        cyc(); clear_inputs();
        pc_select = 2'b01; rw_ex = 5'd4; wreg_ex = 1'b1; m2reg_ex = 1'b1; rt_id = 5'd4; use_rt_id = 1'b1;
        #1;
        n_chk++; if (ifid_flush !== 1'b0 || stall !== 1'b1) begin n_fail++; $display("FAIL rd_stalled got flush %b stall %b want 0 1", ifid_flush, stall); end
        cyc();
        wreg_ex = 1'b0; m2reg_ex = 1'b0;
        #1;
        n_chk++; if (ifid_flush !== 1'b1 || pc_we !== 1'b1) begin n_fail++; $display("FAIL rd_flush got flush %b pc_we %b want 1 1", ifid_flush, pc_we); end
        cyc();
        pc_select = 2'b11; ext_hold = 1'b1; wreg_ex = 1'b1; m2reg_ex = 1'b1;
        #1;
        n_chk++; if (ifid_flush !== 1'b0 || pc_we !== 1'b0 || idex_bubble !== 1'b0) begin n_fail++; $display("FAIL rd_hold got flush %b pc_we %b bubble %b want 0 0 0", ifid_flush, pc_we, idex_bubble); end
        cyc();
        wreg_ex = 1'b0; m2reg_ex = 1'b0; ext_hold = 1'b0; pc_select = 2'b10;
        #1;
        n_chk++; if (ifid_flush !== 1'b1) begin n_fail++; $display("FAIL rd_jr got %b want 1", ifid_flush); end
    endtask

    task automatic test_div();
        cyc(); clear_inputs();
        md_start_id = 1'b1; md_div = 1'b1;
        #1;
        n_chk++; if (md_issue !== 1'b1 || md_busy !== 1'b0) begin n_fail++; $display("FAIL div_issue got issue %b busy %b want 1 0", md_issue, md_busy); end
        for (int k = 1; k <= 33; k++) begin
            cyc();
            md_start_id = 1'b0; md_use_id = 1'b1;
            ext_hold = (k == 10 || k == 11);
            #1;
            n_chk++;
            if (md_busy !== (k <= 32) || md_done !== (k == 32) || stall !== (k <= 32)) begin
                n_fail++;
                $display("FAIL div_seq k=%0d got busy %b done %b stall %b want %b %b %b",
                         k, md_busy, md_done, stall, (k <= 32), (k == 32), (k <= 32));
            end
            n_chk++;
            if (idex_bubble !== ((k <= 32) && !ext_hold)) begin
                n_fail++;
                $display("FAIL div_bubble k=%0d got %b want %b", k, idex_bubble, ((k <= 32) && !ext_hold));
            end
        end
    endtask

    task automatic test_back_to_back();
        cyc(); clear_inputs();
        md_start_id = 1'b1; md_div = 1'b0;
        #1;
        n_chk++; if (md_issue !== 1'b1) begin n_fail++; $display("FAIL b2b_issue0 got %b want 1", md_issue); end
        for (int k = 1; k <= 9; k++) begin
            cyc();
            md_start_id = (k == 2 || k == 4);
            #1;
            n_chk++;
            if (md_issue !== (k == 4) || md_busy !== (k <= 8) || md_done !== (k == 4 || k == 8) || stall !== (k == 2)) begin
                n_fail++;
                $display("FAIL b2b k=%0d got issue %b busy %b done %b stall %b want %b %b %b %b",
                         k, md_issue, md_busy, md_done, stall, (k == 4), (k <= 8), (k == 4 || k == 8), (k == 2));
            end
        end
    endtask

    task automatic test_reset_mid_div();
        cyc(); clear_inputs();
        md_start_id = 1'b1; md_div = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            md_start_id = 1'b0; md_use_id = 1'b1;
        end
        #1;
        n_chk++; if (md_busy !== 1'b1 || stall !== 1'b1) begin n_fail++; $display("FAIL rmd_pre got busy %b stall %b want 1 1", md_busy, stall); end
        reset_0 = 1'b0;
        #1;
        n_chk++; if (md_busy !== 1'b0 || pc_we !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL rmd_async got busy %b pc_we %b stall %b want 0 1 0", md_busy, pc_we, stall); end
        cyc();
        reset_0 = 1'b1;
        cyc();
        #1;
        n_chk++; if (md_busy !== 1'b0 || md_done !== 1'b0 || pc_we !== 1'b1) begin n_fail++; $display("FAIL rmd_after got busy %b done %b pc_we %b want 0 0 1", md_busy, md_done, pc_we); end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_redirect();
        test_div();
        test_back_to_back();
        test_reset_mid_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
